// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared types and helpers for the NoC output arbiters
//
// Purpose : FSM state encoding and modular round-robin pointer advance,
//           shared by noc_output_arbiter and other router arbiters.
// Ports   : none (package).

package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Advance a round-robin index by one, wrapping from n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// rtl/noc_rr_pick.sv - combinational masked round-robin picker
//
// Purpose : picks the first set bit of mask, searching upward from ptr and
//           wrapping from N-1 to 0. Purely combinational.
// Ports   :
//   mask  in  N      candidate requests
//   ptr   in  IDX_W  highest-priority index for this pick (must be < N)
//   pick  out N      one-hot winner, all zero when mask is zero
//   idx   out IDX_W  index of the winner (0 when no winner)
//   valid out 1      a winner exists

module noc_rr_pick
  import noc_arb_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap test.
  logic [IDX_W:0] w_pos [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_pos[k] = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_pos[k] >= (IDX_W+1)'(N)) begin
        w_pos[k] = w_pos[k] - (IDX_W+1)'(N);
      end
    end
  end

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && mask[w_pos[k][IDX_W-1:0]]) begin
        valid                     = 1'b1;
        pick[w_pos[k][IDX_W-1:0]] = 1'b1;
        idx                       = w_pos[k][IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - per-output wormhole arbiter and credit manager
//
// Purpose : round-robin selects one requesting input, holds it until its tail
//           flit is forwarded, and gates every flit on downstream credits.
// Build   : NOC_ARB_STALL_CNT_EN adds the stall_cycles output counting cycles
//           in which a grant is blocked only by an empty credit count.
// Ports   :
//   clk            in  1           NoC clock
//   rst_n          in  1           asynchronous active-low reset
//   req            in  NUM_INPUTS  head-of-queue flit routed to this output
//   req_is_tail    in  NUM_INPUTS  that head flit is a tail
//   disable_turns  in  NUM_INPUTS  input forbidden to use this output
//   grant          out NUM_INPUTS  one-hot, combinational dequeue strobe
//   sel_out        out IDX_W       registered crossbar select
//   send_out       out 1           registered flit-valid
//   credit_in      in  1           downstream freed one slot
//   credits        out CNT_W       current credit count
//   busy           out 1           a packet owns the output
//   credit_err     out 1           sticky credit overflow
//   stall_cycles   out 32          (NOC_ARB_STALL_CNT_EN only) credit stalls

module noc_output_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_INPUTS   = 5,
  parameter int CREDIT_COUNT = 8,
  parameter int IDX_W        = $clog2(NUM_INPUTS),
  parameter int CNT_W        = $clog2(CREDIT_COUNT+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] req_is_tail,
  input  logic [NUM_INPUTS-1:0] disable_turns,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [IDX_W-1:0]      sel_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CNT_W-1:0]      credits,
  output logic                  busy,
  output logic                  credit_err
`ifdef NOC_ARB_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  arb_state_e r_state, w_next_state;
  logic [IDX_W-1:0]      r_rr_ptr, w_next_rr;
  logic [IDX_W-1:0]      r_owner, w_next_owner;
  logic [CNT_W-1:0]      r_credits;
  logic [IDX_W-1:0]      r_sel_out;
  logic                  r_send_out;
  logic                  r_credit_err;

  logic [NUM_INPUTS-1:0] w_eligible;
  logic [NUM_INPUTS-1:0] w_pick;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_valid;
  logic [NUM_INPUTS-1:0] w_owner_oh;
  logic [NUM_INPUTS-1:0] w_grant;
  logic [IDX_W-1:0]      w_grant_idx;
  logic                  w_has_credit;
  logic                  w_fire;
  logic                  w_blocked;

  assign w_eligible   = req & ~disable_turns;
  assign w_has_credit = (r_credits != '0);
  assign w_owner_oh   = NUM_INPUTS'(1) << r_owner;

  noc_rr_pick #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .mask  (w_eligible),
    .ptr   (r_rr_ptr),
    .pick  (w_pick),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  // Next-state and grant decode. w_blocked marks cycles where the only thing
  // stopping a grant is the empty credit count.
  always_comb begin
    w_next_state = r_state;
    w_next_rr    = r_rr_ptr;
    w_next_owner = r_owner;
    w_grant      = '0;
    w_grant_idx  = r_owner;
    w_blocked    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          if (w_has_credit) begin
            w_grant     = w_pick;
            w_grant_idx = w_pick_idx;
            if (|(w_pick & req_is_tail)) begin
              w_next_rr = IDX_W'(rr_next(32'(w_pick_idx), NUM_INPUTS));
            end else begin
              w_next_state = ARB_LOCKED;
              w_next_owner = w_pick_idx;
            end
          end else begin
            w_blocked = 1'b1;
          end
        end
      end
      ARB_LOCKED: begin
        // The owner's disable_turns bit is deliberately ignored here: the
        // turn was legal when the head flit was granted.
        if (req[r_owner]) begin
          if (w_has_credit) begin
            w_grant = w_owner_oh;
            if (req_is_tail[r_owner]) begin
              w_next_state = ARB_IDLE;
              w_next_rr    = IDX_W'(rr_next(32'(r_owner), NUM_INPUTS));
            end
          end else begin
            w_blocked = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // Registers clear asynchronously but grant is combinational from req, so it
  // is gated explicitly to stay low while reset is held.
  assign grant  = rst_n ? w_grant : '0;
  assign w_fire = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_rr_ptr <= w_next_rr;
      r_owner  <= w_next_owner;
    end
  end

  // A return that coincides with a fire cancels out, so it can never
  // overflow even when the count is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits    <= CNT_W'(CREDIT_COUNT);
      r_credit_err <= 1'b0;
    end else begin
      case ({w_fire, credit_in})
        2'b10: r_credits <= r_credits - CNT_W'(1);
        2'b01: begin
          if (r_credits == CNT_W'(CREDIT_COUNT)) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credits <= r_credits + CNT_W'(1);
          end
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_send_out <= 1'b0;
      r_sel_out  <= '0;
    end else begin
      r_send_out <= w_fire;
      if (w_fire) begin
        r_sel_out <= w_grant_idx;
      end
    end
  end

  assign sel_out    = r_sel_out;
  assign send_out   = r_send_out;
  assign credits    = r_credits;
  assign busy       = (r_state == ARB_LOCKED);
  assign credit_err = r_credit_err;

`ifdef NOC_ARB_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_blocked && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  logic w_unused_blocked;
  assign w_unused_blocked = w_blocked;
`endif

endmodule
